weakmem: RTL and testbench

Word-addressed synchronous memory slave sitting directly downstream of the weakcore bus master. It accepts the core's single-outstanding request/acknowledge transactions, instruction fetches and data loads/stores alike, and answers each with a one-cycle acknowledge after a configurable number of wait states. It is the instruction and data store for simulation and small FPGA builds.

---
 rtl/weakmem_pkg.sv | 13 +
 rtl/weakmem_array.sv | 33 +++
 rtl/weakmem.sv | 142 ++++++++++++++
 tb/tb_weakmem.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/weakmem_pkg.sv
// rtl/weakmem_pkg.sv - shared bus definitions for weakmem and future weak-bus slaves
//   Provides the slave FSM state encoding and the bus data width.
package weakmem_pkg;

  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_t;

endpackage

// File: rtl/weakmem_array.sv
// rtl/weakmem_array.sv - single-port synchronous word RAM behind weakmem
//   clk   : rising-edge clock
//   we    : write enable, commits wdata to addr
//   re    : read enable, loads rdata from addr
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read
module weakmem_array
  import weakmem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_DW-1:0]     wdata,
  output logic [BUS_DW-1:0]     rdata
);

  logic [BUS_DW-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/weakmem.sv
// rtl/weakmem.sv - word-addressed wait-state memory slave for the weakcore bus
//   Optional feature macro: WEAKMEM_ERR_EN (adds bus_err, flags misaligned/out-of-range).
//   clk, rst             : clock, synchronous active-high reset
//   bus_req/wr/addr/wdata: request from the master, held until bus_ack
//   bus_rdata            : read data, valid in the bus_ack cycle, held afterwards
//   bus_ack              : one-cycle completion pulse
//   bus_err              : (WEAKMEM_ERR_EN only) qualifies bus_ack
module weakmem
  import weakmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_wr,
  input  logic [BUS_DW-1:0] bus_addr,
  input  logic [BUS_DW-1:0] bus_wdata,
  output logic [BUS_DW-1:0] bus_rdata,
`ifdef WEAKMEM_ERR_EN
  output logic              bus_err,
`endif
  output logic              bus_ack
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("weakmem: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

  bus_state_t              state;
  logic [3:0]              cnt;
  logic                    lat_wr;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [BUS_DW-1:0]       lat_wdata;
  logic                    rdata_sel;

  logic                    in_idle;
  logic                    enter_ack;
  logic                    cur_wr;
  logic                    cur_err;
  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [BUS_DW-1:0]       cur_wdata;
  logic                    arr_we;
  logic                    arr_re;
  logic [BUS_DW-1:0]       arr_rdata;

`ifdef WEAKMEM_ERR_EN
  logic lat_err;
  logic req_err;
  logic err_q;
  assign req_err = (bus_addr[1:0] != 2'b00) || ((bus_addr >> (ADDR_WIDTH + 2)) != '0);
  assign cur_err = in_idle ? req_err : lat_err;
  assign bus_err = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^{bus_addr[1:0], bus_addr >> (ADDR_WIDTH + 2)};
  assign cur_err     = 1'b0;
`endif

  // With zero wait states the ACK-entry edge is the request edge itself, so the
  // array must see the live bus fields there rather than the latched copies.
  assign in_idle   = (state == ST_IDLE);
  assign cur_wr    = in_idle ? bus_wr : lat_wr;
  assign cur_idx   = in_idle ? bus_addr[ADDR_WIDTH+1:2] : lat_idx;
  assign cur_wdata = in_idle ? bus_wdata : lat_wdata;

  assign enter_ack = ~rst & ((in_idle & bus_req & NO_WAIT) |
                             ((state == ST_WAIT) & (cnt == 4'd0)));
  assign arr_we    = enter_ack &  cur_wr & ~cur_err;
  assign arr_re    = enter_ack & ~cur_wr & ~cur_err;

  weakmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // The array read register has no reset; rdata_sel forces the bus to zero
  // after reset and after an errored read.
  assign bus_rdata = rdata_sel ? arr_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      bus_ack   <= 1'b0;
      rdata_sel <= 1'b0;
`ifdef WEAKMEM_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      bus_ack <= enter_ack;
`ifdef WEAKMEM_ERR_EN
      err_q   <= enter_ack & cur_err;
`endif
      if (enter_ack && !cur_wr) begin
        rdata_sel <= ~cur_err;
      end
      case (state)
        ST_IDLE: begin
          if (bus_req) begin
            lat_wr    <= bus_wr;
            lat_idx   <= bus_addr[ADDR_WIDTH+1:2];
            lat_wdata <= bus_wdata;
`ifdef WEAKMEM_ERR_EN
            lat_err   <= req_err;
`endif
            if (NO_WAIT) begin
              state <= ST_ACK;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weakmem.sv
// tb/tb_weakmem.sv - directed self-checking bench for weakmem (WAIT_CYCLES 0 and 3)
module tb_weakmem;

  logic        clk;
  logic        rst;
  logic        req0, wr0, req3, wr3;
  logic [31:0] addr0, wd0, addr3, wd3;
  logic [31:0] rdata0, rdata3;
  logic        ack0, ack3;
`ifdef WEAKMEM_ERR_EN
  logic        err0, err3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  weakmem #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst), .bus_req(req0), .bus_wr(wr0), .bus_addr(addr0),
    .bus_wdata(wd0), .bus_rdata(rdata0),
`ifdef WEAKMEM_ERR_EN
    .bus_err(err0),
`endif
    .bus_ack(ack0)
  );

  weakmem #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .rst(rst), .bus_req(req3), .bus_wr(wr3), .bus_addr(addr3),
    .bus_wdata(wd3), .bus_rdata(rdata3),
`ifdef WEAKMEM_ERR_EN
    .bus_err(err3),
`endif
    .bus_ack(ack3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Runs one transaction on the selected DUT (0 or 3). Called at a negedge;
  // returns at the negedge inside the ack cycle. lat counts negedges to ack.
  task automatic xfer(input int sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit hold,
                      output logic [31:0] rd, output int lat, output logic err,
                      output bit early_nz);
    logic a;
    if (sel == 0) begin
      req0 = 1'b1; wr0 = wr; addr0 = addr; wd0 = wd;
    end else begin
      req3 = 1'b1; wr3 = wr; addr3 = addr; wd3 = wd;
    end
    lat      = 0;
    early_nz = 1'b0;
    a        = 1'b0;
    while (!a && lat < 40) begin
      @(negedge clk);
      lat++;
      a = (sel == 0) ? ack0 : ack3;
      if (!a && ((sel == 0) ? rdata0 : rdata3) != 32'h0) early_nz = 1'b1;
    end
    rd = (sel == 0) ? rdata0 : rdata3;
`ifdef WEAKMEM_ERR_EN
    err = (sel == 0) ? err0 : err3;
`else
    err = 1'b0;
`endif
    if (!hold) begin
      if (sel == 0) req0 = 1'b0; else req3 = 1'b0;
    end
  endtask

  logic [31:0] rd;
  int          lat;
  logic        err;
  bit          enz;
  bit          saw_ack;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
    req3 = 1'b0; wr3 = 1'b0; addr3 = '0; wd3 = '0;
    idle(3);
    rst = 1'b0;
    check_eq("rst_ack0",   32'(ack0), 32'd0);
    check_eq("rst_rdata0", rdata0,    32'h0);
    check_eq("rst_ack3",   32'(ack3), 32'd0);
    check_eq("rst_rdata3", rdata3,    32'h0);
    idle(1);

    // Zero wait states: write then read word 0.
    xfer(0, 1'b1, 32'h0, 32'h00000013, 1'b0, rd, lat, err, enz);
    check_eq("w0_lat", 32'(lat), 32'd1);
    idle(2);
    xfer(0, 1'b0, 32'h0, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("r0_lat",   32'(lat), 32'd1);
    check_eq("r0_rdata", rd,       32'h00000013);
    idle(1);
    check_eq("r0_ack_one_cycle", 32'(ack0), 32'd0);
    check_eq("r0_rdata_hold",    rdata0,    32'h00000013);
    idle(1);

    // Back-to-back write then read with req held through the first ack.
    xfer(0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, rd, lat, err, enz);
    check_eq("b2b_w_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("b2b_r_lat",   32'(lat), 32'd2);
    check_eq("b2b_r_rdata", rd,       32'hDEADBEEF);
    idle(2);

    // Three wait states.
    xfer(3, 1'b1, 32'h4, 32'hCAFEF00D, 1'b0, rd, lat, err, enz);
    check_eq("w3_lat", 32'(lat), 32'd4);
    idle(2);
    xfer(3, 1'b0, 32'h4, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("r3_first_rdata", rd, 32'hCAFEF00D);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_eq("r3_rdata_after_rst", rdata3, 32'h0);
    idle(1);
    xfer(3, 1'b0, 32'h4, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("r3_lat",        32'(lat), 32'd4);
    check_eq("r3_early_zero", 32'(enz), 32'd0);
    check_eq("r3_rdata",      rd,       32'hCAFEF00D);
    idle(2);

    // Reset during WAIT of a write: no ack, write discarded.
    xfer(3, 1'b1, 32'h8, 32'h11112222, 1'b0, rd, lat, err, enz);
    idle(2);
    req3 = 1'b1; wr3 = 1'b1; addr3 = 32'h8; wd3 = 32'h12345678;
    saw_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      saw_ack |= ack3;
    end
    rst  = 1'b1;
    req3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_state_idle", 32'(u_dut3.state), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_ack |= ack3;
    end
    check_eq("abort_no_ack", 32'(saw_ack), 32'd0);
    xfer(3, 1'b0, 32'h8, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("abort_read_lat", 32'(lat), 32'd4);
    check_eq("abort_old_data", rd,       32'h11112222);
    idle(2);

`ifdef WEAKMEM_ERR_EN
    xfer(0, 1'b1, 32'h4, 32'h0BADF00D, 1'b0, rd, lat, err, enz);
    check_eq("err_good_w_err", 32'(err), 32'd0);
    idle(2);
    xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, 1'b0, rd, lat, err, enz);
    check_eq("err_mis_w_lat", 32'(lat), 32'd1);
    check_eq("err_mis_w_err", 32'(err), 32'd1);
    idle(2);
    xfer(0, 1'b0, 32'h4, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("err_word4_err",   32'(err), 32'd0);
    check_eq("err_word4_rdata", rd,       32'h0BADF00D);
    idle(2);
    xfer(0, 1'b0, 32'h1000, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("err_oor_err",   32'(err), 32'd1);
    check_eq("err_oor_rdata", rd,       32'h0);
    idle(2);
`else
    // Out-of-range and low address bits alias onto the array.
    xfer(0, 1'b1, 32'h1000, 32'hA5A5A5A5, 1'b0, rd, lat, err, enz);
    check_eq("alias_w_lat", 32'(lat), 32'd1);
    idle(2);
    xfer(0, 1'b0, 32'h0, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("alias_r_rdata", rd, 32'hA5A5A5A5);
    idle(2);
    xfer(0, 1'b0, 32'h43, 32'h0, 1'b0, rd, lat, err, enz);
    check_eq("alias_lowbits_rdata", rd, 32'hDEADBEEF);
    idle(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
